// File: rtl/music_seq_ctrl.sv
// Song playback controller: quarter-beat timebase, 4-song select, STOP/PLAY/PAUSE FSM.
// Optional tempo control (tempo_up/tempo_down/tempo_lvl) is built when TEMPO_ADJ_EN is defined.
module music_seq_ctrl #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BEAT_HZ   = 8,
  parameter int SONG0_LEN = 216,
  parameter int SONG1_LEN = 216,
  parameter int SONG2_LEN = 216,
  parameter int SONG3_LEN = 216
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_pause,
  input  logic       stop,
  input  logic       next,
  input  logic       prev,
  input  logic       loop_en,
`ifdef TEMPO_ADJ_EN
  input  logic       tempo_up,
  input  logic       tempo_down,
  output logic [1:0] tempo_lvl,
`endif
  output logic [7:0] beat_num,
  output logic [1:0] song_sel,
  output logic       mute,
  output logic       playing,
  output logic       song_done
);

  localparam int DIV = CLK_FREQ / BEAT_HZ;
  // Sized for the slowest tempo level (2*DIV) even when tempo control is absent.
  localparam int CW  = $clog2(2 * DIV + 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_last;
  logic [7:0]    last_beat;

  always_comb begin
    last_beat = 8'(SONG0_LEN - 1);
    case (song_sel)
      2'd1:    last_beat = 8'(SONG1_LEN - 1);
      2'd2:    last_beat = 8'(SONG2_LEN - 1);
      2'd3:    last_beat = 8'(SONG3_LEN - 1);
      default: last_beat = 8'(SONG0_LEN - 1);
    endcase
  end

  always_comb begin
    div_last = CW'(DIV - 1);
`ifdef TEMPO_ADJ_EN
    case (tempo_lvl)
      2'd0:    div_last = CW'(2 * DIV - 1);
      2'd2:    div_last = CW'(DIV / 2 - 1);
      default: div_last = CW'(DIV - 1);
    endcase
`endif
  end

  // Button pulses take precedence over the divider, so a coincident tick is dropped.
  always_ff @(posedge clk) begin
    song_done <= 1'b0;
    if (rst) begin
      state    <= ST_STOP;
      div_cnt  <= '0;
      beat_num <= 8'd0;
      song_sel <= 2'd0;
      mute     <= 1'b1;
      playing  <= 1'b0;
`ifdef TEMPO_ADJ_EN
      tempo_lvl <= 2'd1;
`endif
    end else if (stop) begin
      state    <= ST_STOP;
      div_cnt  <= '0;
      beat_num <= 8'd0;
      mute     <= 1'b1;
      playing  <= 1'b0;
    end else if (next || prev) begin
      song_sel <= next ? song_sel + 2'd1 : song_sel - 2'd1;
      div_cnt  <= '0;
      beat_num <= 8'd0;
    end else if (play_pause) begin
      if (state == ST_PLAY) begin
        state   <= ST_PAUSE;
        mute    <= 1'b1;
        playing <= 1'b0;
      end else begin
        if (state == ST_STOP) begin
          div_cnt  <= '0;
          beat_num <= 8'd0;
        end
        state   <= ST_PLAY;
        mute    <= 1'b0;
        playing <= 1'b1;
      end
`ifdef TEMPO_ADJ_EN
    end else if (tempo_up && tempo_lvl != 2'd2) begin
      tempo_lvl <= tempo_lvl + 2'd1;
      div_cnt   <= '0;
    end else if (!tempo_up && tempo_down && tempo_lvl != 2'd0) begin
      tempo_lvl <= tempo_lvl - 2'd1;
      div_cnt   <= '0;
`endif
    end else if (state == ST_PLAY) begin
      if (div_cnt == div_last) begin
        div_cnt <= '0;
        if (beat_num == last_beat) begin
          beat_num <= 8'd0;
          if (!loop_en) begin
            state     <= ST_STOP;
            mute      <= 1'b1;
            playing   <= 1'b0;
            song_done <= 1'b1;
          end
        end else begin
          beat_num <= beat_num + 8'd1;
        end
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl: DIV=10, song 0 = 4 beats, song 1 = 3 beats.
module tb_music_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       play_pause = 1'b0;
  logic       stop = 1'b0;
  logic       next = 1'b0;
  logic       prev = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] beat_num;
  logic [1:0] song_sel;
  logic       mute;
  logic       playing;
  logic       song_done;
`ifdef TEMPO_ADJ_EN
  logic       tempo_up = 1'b0;
  logic       tempo_down = 1'b0;
  logic [1:0] tempo_lvl;
`endif

  int total = 0;
  int bad = 0;

  music_seq_ctrl #(
    .CLK_FREQ(80), .BEAT_HZ(8),
    .SONG0_LEN(4), .SONG1_LEN(3), .SONG2_LEN(5), .SONG3_LEN(6)
  ) dut (
    .clk(clk), .rst(rst),
    .play_pause(play_pause), .stop(stop), .next(next), .prev(prev),
    .loop_en(loop_en),
`ifdef TEMPO_ADJ_EN
    .tempo_up(tempo_up), .tempo_down(tempo_down), .tempo_lvl(tempo_lvl),
`endif
    .beat_num(beat_num), .song_sel(song_sel), .mute(mute),
    .playing(playing), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Inputs change on negedge; outputs are read on negedge after the sampling posedge.
  task automatic btn(input logic s, input logic n, input logic p, input logic pp);
    stop = s; next = n; prev = p; play_pause = pp;
    @(negedge clk);
    stop = 1'b0; next = 1'b0; prev = 1'b0; play_pause = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (beat_num !== 8'd0) begin bad++; $display("FAIL reset_beat: got %0d want 0", beat_num); end
    total++; if (song_sel !== 2'd0) begin bad++; $display("FAIL reset_song: got %0d want 0", song_sel); end
    total++; if (mute !== 1'b1) begin bad++; $display("FAIL reset_mute: got %0b want 1", mute); end
    total++; if (playing !== 1'b0) begin bad++; $display("FAIL reset_playing: got %0b want 0", playing); end
    total++; if (song_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", song_done); end
`ifdef TEMPO_ADJ_EN
    total++; if (tempo_lvl !== 2'd1) begin bad++; $display("FAIL reset_tempo: got %0d want 1", tempo_lvl); end
`endif
  endtask

  task automatic test_play_once();
    logic [7:0] exp;
    do_reset();
    loop_en = 1'b0;
    btn(0, 0, 0, 1);
    total++; if (mute !== 1'b0) begin bad++; $display("FAIL play_mute: got %0b want 0", mute); end
    total++; if (playing !== 1'b1) begin bad++; $display("FAIL play_playing: got %0b want 1", playing); end
    total++; if (beat_num !== 8'd0) begin bad++; $display("FAIL play_beat0: got %0d want 0", beat_num); end
    for (int b = 1; b <= 4; b++) begin
      repeat (9) @(negedge clk);
      total++; if (beat_num !== 8'(b - 1)) begin bad++; $display("FAIL once_hold: got %0d want %0d", beat_num, b - 1); end
      @(negedge clk);
      exp = (b == 4) ? 8'd0 : 8'(b);
      total++; if (beat_num !== exp) begin bad++; $display("FAIL once_step: got %0d want %0d", beat_num, exp); end
      total++; if (song_done !== (b == 4)) begin bad++; $display("FAIL once_done: got %0b want %0b", song_done, b == 4); end
    end
    total++; if (mute !== 1'b1) begin bad++; $display("FAIL end_mute: got %0b want 1", mute); end
    total++; if (playing !== 1'b0) begin bad++; $display("FAIL end_playing: got %0b want 0", playing); end
    @(negedge clk);
    total++; if (song_done !== 1'b0) begin bad++; $display("FAIL done_width: got %0b want 0", song_done); end
  endtask

  task automatic test_loop();
    int seq [5] = '{1, 2, 3, 0, 1};
    logic seen_done = 1'b0;
    logic dropped = 1'b0;
    do_reset();
    loop_en = 1'b1;
    btn(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      repeat (10) begin
        @(negedge clk);
        if (song_done) seen_done = 1'b1;
        if (!playing) dropped = 1'b1;
      end
      total++; if (beat_num !== 8'(seq[i])) begin bad++; $display("FAIL loop_beat: got %0d want %0d", beat_num, seq[i]); end
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL loop_done: got %0b want 0", seen_done); end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL loop_playing: dropped=%0b want 0", dropped); end
    loop_en = 1'b0;
  endtask

  task automatic test_pause();
    int moved = 0;
    do_reset();
    btn(0, 0, 0, 1);
    repeat (20) @(negedge clk);
    total++; if (beat_num !== 8'd2) begin bad++; $display("FAIL pause_pre: got %0d want 2", beat_num); end
    repeat (4) @(negedge clk);
    btn(0, 0, 0, 1);
    total++; if (mute !== 1'b1) begin bad++; $display("FAIL pause_mute: got %0b want 1", mute); end
    total++; if (playing !== 1'b0) begin bad++; $display("FAIL pause_playing: got %0b want 0", playing); end
    repeat (50) begin
      @(negedge clk);
      if (beat_num !== 8'd2) moved++;
    end
    total++; if (moved !== 0) begin bad++; $display("FAIL pause_hold: got %0d moves want 0", moved); end
    btn(0, 0, 0, 1);
    total++; if (playing !== 1'b1) begin bad++; $display("FAIL resume_playing: got %0b want 1", playing); end
    repeat (5) @(negedge clk);
    total++; if (beat_num !== 8'd2) begin bad++; $display("FAIL resume_hold: got %0d want 2", beat_num); end
    @(negedge clk);
    total++; if (beat_num !== 8'd3) begin bad++; $display("FAIL resume_step: got %0d want 3", beat_num); end
    btn(0, 0, 0, 1);
    btn(1, 0, 0, 0);
    total++; if (beat_num !== 8'd0) begin bad++; $display("FAIL pause_stop_beat: got %0d want 0", beat_num); end
    total++; if (playing !== 1'b0) begin bad++; $display("FAIL pause_stop_playing: got %0b want 0", playing); end
  endtask

  task automatic test_song_select();
    do_reset();
    btn(0, 0, 1, 0);
    total++; if (song_sel !== 2'd3) begin bad++; $display("FAIL prev_wrap: got %0d want 3", song_sel); end
    btn(0, 1, 0, 0);
    btn(0, 1, 0, 0);
    total++; if (song_sel !== 2'd1) begin bad++; $display("FAIL next_twice: got %0d want 1", song_sel); end
    loop_en = 1'b0;
    btn(0, 0, 0, 1);
    repeat (10) @(negedge clk);
    total++; if (beat_num !== 8'd1) begin bad++; $display("FAIL s1_beat1: got %0d want 1", beat_num); end
    repeat (19) @(negedge clk);
    total++; if (beat_num !== 8'd2 || song_done !== 1'b0) begin bad++; $display("FAIL s1_last: got beat=%0d done=%0b want 2/0", beat_num, song_done); end
    @(negedge clk);
    total++; if (beat_num !== 8'd0) begin bad++; $display("FAIL s1_wrap: got %0d want 0", beat_num); end
    total++; if (song_done !== 1'b1) begin bad++; $display("FAIL s1_done: got %0b want 1", song_done); end
    total++; if (song_sel !== 2'd1 || playing !== 1'b0) begin bad++; $display("FAIL s1_stop: got sel=%0d play=%0b want 1/0", song_sel, playing); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn(0, 0, 0, 1);
    repeat (15) @(negedge clk);
    btn(1, 1, 0, 1);
    total++; if (playing !== 1'b0 || mute !== 1'b1) begin bad++; $display("FAIL prio_stop: got play=%0b mute=%0b want 0/1", playing, mute); end
    total++; if (song_sel !== 2'd0) begin bad++; $display("FAIL prio_song: got %0d want 0", song_sel); end
    total++; if (beat_num !== 8'd0) begin bad++; $display("FAIL prio_beat: got %0d want 0", beat_num); end
    btn(0, 1, 1, 1);
    total++; if (song_sel !== 2'd1 || playing !== 1'b0) begin bad++; $display("FAIL prio_next: got sel=%0d play=%0b want 1/0", song_sel, playing); end
  endtask

  task automatic test_end_next();
    logic seen_done = 1'b0;
    do_reset();
    loop_en = 1'b0;
    btn(0, 0, 0, 1);
    repeat (39) @(negedge clk);
    total++; if (beat_num !== 8'd3) begin bad++; $display("FAIL endnext_pre: got %0d want 3", beat_num); end
    btn(0, 1, 0, 0);
    total++; if (song_sel !== 2'd1 || beat_num !== 8'd0) begin bad++; $display("FAIL endnext_sel: got sel=%0d beat=%0d want 1/0", song_sel, beat_num); end
    total++; if (playing !== 1'b1 || song_done !== 1'b0) begin bad++; $display("FAIL endnext_state: got play=%0b done=%0b want 1/0", playing, song_done); end
    repeat (9) begin
      @(negedge clk);
      if (song_done) seen_done = 1'b1;
    end
    total++; if (beat_num !== 8'd0 || seen_done !== 1'b0) begin bad++; $display("FAIL endnext_hold: got beat=%0d done=%0b want 0/0", beat_num, seen_done); end
    @(negedge clk);
    total++; if (beat_num !== 8'd1) begin bad++; $display("FAIL endnext_step: got %0d want 1", beat_num); end
  endtask

  task automatic test_mid_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1; play_pause = 1'b1; next = 1'b1;
    @(negedge clk);
    rst = 1'b0; play_pause = 1'b0; next = 1'b0;
    total++; if (beat_num !== 8'd0 || song_sel !== 2'd0) begin bad++; $display("FAIL midrst_regs: got beat=%0d sel=%0d want 0/0", beat_num, song_sel); end
    total++; if (playing !== 1'b0 || mute !== 1'b1) begin bad++; $display("FAIL midrst_state: got play=%0b mute=%0b want 0/1", playing, mute); end
  endtask

`ifdef TEMPO_ADJ_EN
  task automatic test_tempo();
    do_reset();
    repeat (3) begin
      tempo_up = 1'b1; @(negedge clk); tempo_up = 1'b0;
    end
    total++; if (tempo_lvl !== 2'd2) begin bad++; $display("FAIL tempo_up_sat: got %0d want 2", tempo_lvl); end
    btn(0, 0, 0, 1);
    for (int b = 1; b <= 2; b++) begin
      repeat (4) @(negedge clk);
      total++; if (beat_num !== 8'(b - 1)) begin bad++; $display("FAIL fast_hold: got %0d want %0d", beat_num, b - 1); end
      @(negedge clk);
      total++; if (beat_num !== 8'(b)) begin bad++; $display("FAIL fast_step: got %0d want %0d", beat_num, b); end
    end
    btn(1, 0, 0, 0);
    repeat (3) begin
      tempo_down = 1'b1; @(negedge clk); tempo_down = 1'b0;
    end
    total++; if (tempo_lvl !== 2'd0) begin bad++; $display("FAIL tempo_down_sat: got %0d want 0", tempo_lvl); end
    btn(0, 0, 0, 1);
    repeat (19) @(negedge clk);
    total++; if (beat_num !== 8'd0) begin bad++; $display("FAIL slow_hold: got %0d want 0", beat_num); end
    @(negedge clk);
    total++; if (beat_num !== 8'd1) begin bad++; $display("FAIL slow_step: got %0d want 1", beat_num); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_play_once();
    test_loop();
    test_pause();
    test_song_select();
    test_simultaneous();
    test_end_next();
    test_mid_reset();
`ifdef TEMPO_ADJ_EN
    test_tempo();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
